// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory-stage access unit:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   - control FSM state enum
//   - timeout counter width
//   - helpers for alignment checking, byte-enable and store-lane generation
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  // A command is rejected before touching memory if its size is illegal or
  // its address is not naturally aligned for that size.
  function automatic logic bad_cmd(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: bad_cmd = 1'b0;
      SZ_HALF: bad_cmd = lo[0];
      SZ_WORD: bad_cmd = (lo != 2'b00);
      default: bad_cmd = 1'b1;
    endcase
  endfunction

  // Little-endian byte enables; loads use the same lanes as a store.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_enables = 4'b0001 << lo;
      SZ_HALF: byte_enables = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_enables = 4'b1111;
      default: byte_enables = 4'b0000;
    endcase
  endfunction

  // Store data is replicated across every lane so memory can pick it up with
  // the byte enables alone, independent of the address offset.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_lanes = {4{wdata[7:0]}};
      SZ_HALF: store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// -----------------------------------------------------------------------------
// mem_access_unit_load_align
// Combinational load-lane select and extend.
//   rdata    in  32  raw word from data memory
//   lo       in   2  byte offset (addr[1:0])
//   size     in   2  access size encoding
//   sign_ext in   1  1 = sign-extend, 0 = zero-extend
//   result   out 32  right-justified, extended load value
// -----------------------------------------------------------------------------
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[8*lo +: 8];
  assign half_lane = lo[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    result = rdata;
    case (size)
      SZ_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store unit: runs a req/ack handshake with data memory,
// generates byte enables and replicated store data, aligns/extends load data
// and produces the writeback select for the register-file writeback mux.
//
// Parameters
//   TIMEOUT            cycles mem_req may stay high without ack (1..255)
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, we, size, sign_ext, addr_in, wdata_in   command (sampled in IDLE)
//   busy, done, err    status: busy outside IDLE, done/err one-cycle pulses
//   load_data, wb_sel  registered writeback word and select
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be   memory request
//   mem_rdata, mem_ack memory response
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q, sext_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      aligned;

  logic accept, expired, acked;

  assign accept  = (state_q == IDLE) && start;
  assign acked   = (state_q == WAIT) && mem_ack;
  assign expired = (state_q == WAIT) && !mem_ack && (cnt_q == CNT_LAST);

  // Status and request strobes decode straight from the state register so a
  // reset drops them immediately, without waiting for a clock edge.
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE) || (state_q == ERR);
  assign err     = (state_q == ERR);
  assign mem_req = (state_q == WAIT);
  assign mem_we  = mem_req & we_q;

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = bad_cmd(size, addr_in[1:0]) ? ERR : WAIT;
      WAIT:    if (mem_ack) state_d = DONE;
               else if (cnt_q == CNT_LAST) state_d = ERR;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch: request fields stay constant for the whole WAIT phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
    end else if (accept) begin
      we_q    <= we;
      sext_q  <= sign_ext;
      size_q  <= size;
      addr_q  <= addr_in;
      wdata_q <= store_lanes(size, wdata_in);
      be_q    <= byte_enables(size, addr_in[1:0]);
    end
  end

  // Timeout counter: zero on entry to WAIT, one step per WAIT cycle, so
  // mem_req is high for exactly TIMEOUT cycles before giving up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (state_q == WAIT)    cnt_q <= cnt_q + 1'b1;
    else                         cnt_q <= '0;
  end

  mem_access_unit_load_align u_load_align (
    .rdata    (mem_rdata),
    .lo       (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sext_q),
    .result   (aligned)
  );

  // Writeback: load_data only moves on a successful load ack; wb_sel is
  // rewritten on every completion (ack, timeout or rejected command).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data <= '0;
      wb_sel    <= 1'b0;
    end else begin
      if (acked && !we_q) load_data <= aligned;
      if (acked)
        wb_sel <= !we_q;
      else if (expired || (accept && bad_cmd(size, addr_in[1:0])))
        wb_sel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed, self-checking bench for mem_access_unit (TIMEOUT = 4).
// Cycle n is the interval after the n-th rising edge following a command
// strobe; inputs are driven and outputs sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, we, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [31:0] addr_in, wdata_in, mem_rdata;
  logic        busy, done, err, wb_sel, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .wb_sel    (wb_sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle in cycle 0; returns in cycle 1.
  task automatic issue(input logic w, input logic [1:0] s, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    we = w; size = s; sign_ext = sx; addr_in = a; wdata_in = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || wb_sel !== 1'b0) begin errors++; $display("FAIL reset_strobes: req=%b we=%b wb_sel=%b want 000", mem_req, mem_we, wb_sel); end
    checks++; if (load_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin errors++; $display("FAIL reset_data: ld=%h addr=%h wd=%h be=%b want zeros", load_data, mem_addr, mem_wdata, mem_be); end
    // An ack while idle must not start anything.
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || load_data !== 32'h0) begin errors++; $display("FAIL idle_ack_ignored: busy=%b done=%b ld=%h want 0 0 0", busy, done, load_data); end
  endtask

  task automatic test_word_load();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wl_req_c1: req=%b busy=%b want 1 1", mem_req, busy); end
    checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin errors++; $display("FAIL wl_fields: addr=%h be=%b we=%b want 00000100 1111 0", mem_addr, mem_be, mem_we); end
    tick();
    checks++; if (mem_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wl_c2: req=%b done=%b want 1 0", mem_req, done); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL wl_done_c4: done=%b err=%b req=%b want 1 0 0", done, err, mem_req); end
    checks++; if (load_data !== 32'hDEADBEEF || wb_sel !== 1'b1) begin errors++; $display("FAIL wl_result: ld=%h wb_sel=%b want deadbeef 1", load_data, wb_sel); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wb_sel !== 1'b1) begin errors++; $display("FAIL wl_c5: busy=%b done=%b wb_sel=%b want 0 0 1", busy, done, wb_sel); end
  endtask

  task automatic test_byte_load(input logic sx, input logic [31:0] exp);
    issue(1'b0, 2'b00, sx, 32'h0000_0103, 32'h0);
    checks++; if (mem_be !== 4'b1000 || mem_addr !== 32'h100 || mem_req !== 1'b1) begin errors++; $display("FAIL bl_fields sx=%b: be=%b addr=%h req=%b want 1000 00000100 1", sx, mem_be, mem_addr, mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'h80112233;
    tick();
    mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || load_data !== exp || wb_sel !== 1'b1) begin errors++; $display("FAIL bl_result sx=%b: done=%b ld=%h wb_sel=%b want 1 %h 1", sx, done, load_data, wb_sel, exp); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bl_idle sx=%b: busy=%b want 0", sx, busy); end
  endtask

  task automatic test_half_store();
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h0000_ABCD);
    checks++; if (mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h204) begin errors++; $display("FAIL hs_fields: we=%b be=%b wd=%h addr=%h want 1 1100 abcdabcd 00000204", mem_we, mem_be, mem_wdata, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0 || wb_sel !== 1'b0) begin errors++; $display("FAIL hs_done_c2: done=%b err=%b wb_sel=%b want 1 0 0", done, err, wb_sel); end
    checks++; if (load_data !== 32'h0000_0080) begin errors++; $display("FAIL hs_ld_hold: ld=%h want 00000080", load_data); end
    tick();
  endtask

  task automatic test_misaligned();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0);
    checks++; if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_c1: done=%b err=%b req=%b want 1 1 0", done, err, mem_req); end
    checks++; if (load_data !== 32'h0000_0080 || wb_sel !== 1'b0) begin errors++; $display("FAIL mis_wb: ld=%h wb_sel=%b want 00000080 0", load_data, wb_sel); end
    tick();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mis_c2: busy=%b req=%b done=%b want 0 0 0", busy, mem_req, done); end
    // Illegal size at an aligned address is rejected the same way.
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'h0);
    checks++; if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL ill_c1: done=%b err=%b req=%b want 1 1 0", done, err, mem_req); end
    tick();
  endtask

  task automatic test_timeout();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      checks++; if (mem_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL to_req_c%0d: req=%b done=%b want 1 0", c, mem_req, done); end
      if (c == 2) begin
        start = 1'b1; addr_in = 32'h0000_0400;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0 || wb_sel !== 1'b0) begin errors++; $display("FAIL to_c5: done=%b err=%b req=%b wb_sel=%b want 1 1 0 0", done, err, mem_req, wb_sel); end
    tick();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL to_c6_not_queued: busy=%b req=%b want 0 0", busy, mem_req); end
    tick();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL to_c7_not_queued: busy=%b req=%b want 0 0", busy, mem_req); end
  endtask

  task automatic test_reset_mid_wait();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmw_req_c1: req=%b want 1", mem_req); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || load_data !== 32'h0 || done !== 1'b0) begin errors++; $display("FAIL rmw_async: req=%b busy=%b ld=%h done=%b want 0 0 0 0", mem_req, busy, load_data, done); end
    tick();
    rst_n = 1'b1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmw_no_done: done=%b busy=%b want 0 0", done, busy); end
    tick();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h204) begin errors++; $display("FAIL rmw_restart: req=%b addr=%h want 1 00000204", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0 || load_data !== 32'h1234_5678 || wb_sel !== 1'b1) begin errors++; $display("FAIL rmw_result: done=%b err=%b ld=%h wb_sel=%b want 1 0 12345678 1", done, err, load_data, wb_sel); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr_in = '0; wdata_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_word_load();
    test_byte_load(1'b1, 32'hFFFF_FF80);
    test_byte_load(1'b0, 32'h0000_0080);
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Data-memory access unit for the processor's memory stage.
- Takes a load/store command (address and store data from the ALU path) and runs a req/ack handshake with data memory.
- For loads, aligns and extends the returned word; for stores, generates byte enables.
- Produces the memory-side writeback word and the writeback select that the register-file writeback mux consumes.

## Interface
Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ack before aborting (1..255).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous reset, active low.
- Command side:
  - start  in  1  command strobe, sampled only in IDLE.
  - we  in  1  1 = store, 0 = load.
  - size  in  2  00 byte, 01 half, 10 word, 11 illegal.
  - sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
  - addr_in  in  32  byte address.
  - wdata_in  in  32  store data, right-justified.
  - busy  out  1  high in any state other than IDLE.
  - done  out  1  one-cycle completion pulse.
  - err  out  1  one-cycle pulse coincident with done on misalign, illegal size or timeout.
- Writeback side:
  - load_data  out  32  aligned/extended load result, registered.
  - wb_sel  out  1  1 = writeback takes memory data, 0 = ALU data.
- Memory side:
  - mem_req  out  1  request valid.
  - mem_we  out  1  write request.
  - mem_addr  out  32  word address, {addr_in[31:2],2'b00}.
  - mem_wdata  out  32  lane-replicated store data.
  - mem_be  out  4  byte enables, little-endian.
  - mem_rdata  in  32  read word, valid with mem_ack.
  - mem_ack  in  1  completes the outstanding request.

## Operation
- FSM states:
  - IDLE: start=1 latches we/size/sign_ext/addr_in/wdata_in.
    - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=11 → ERR.
    - Otherwise → WAIT.
  - WAIT: mem_req=1; request fields held constant from latched values. Timeout counter starts at 0 and increments each cycle.
    - mem_ack=1 → DONE.
    - Counter reaches TIMEOUT-1 without ack → ERR; mem_req drops.
  - DONE: done=1 → IDLE.
  - ERR: done=1, err=1, no memory access → IDLE.
- start in any state other than IDLE is ignored; not queued.
- Stores:
  - Byte: mem_wdata = {4{wdata[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - Half: mem_wdata = {2{wdata[15:0]}}, mem_be = addr[1] ? 1100 : 0011.
  - Word: mem_wdata = wdata, mem_be = 1111.
- Loads:
  - mem_be asserted as for a store of the same size.
  - At ack, the lane is selected by addr[1:0] and extended per sign_ext into load_data.
- load_data is updated only on a successful load ack; otherwise it holds.
- wb_sel is updated in the DONE/ERR cycle: 1 for a successful load, 0 for a store or any error. It holds until the next completion.

## Timing
- Reset values:
  - state IDLE.
  - busy, done, err, mem_req, mem_we, wb_sel all 0.
  - load_data, mem_addr, mem_wdata all 0; mem_be 0000.
- Successful access:
  - start at cycle 0 → mem_req high from cycle 1.
  - Ack in cycle k≥1 → done and final load_data/wb_sel in cycle k+1.
  - Minimum latency is 2 cycles (start to done); busy goes low in cycle k+2.
- mem_ack outside WAIT is ignored.
- Error path:
  - Misaligned or illegal command: done=err=1 in cycle 1; mem_req never asserted.
  - Timeout: mem_req high for exactly TIMEOUT cycles; done=err=1 in the following cycle.
- start coincident with done: ignored; a new command is accepted only with busy=0.
- Reset mid-WAIT: mem_req drops asynchronously, no done pulse, load_data clears.

## Structure
- Shared package holds:
  - Size encodings SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL.
  - State enum IDLE / WAIT / DONE / ERR.
  - Timeout counter width (8).
- One natural sub-module: load_align, a combinational lane select and extend (rdata, addr[1:0], size, sign_ext → 32-bit result). Instantiated once.

## Test plan
- Word load at 0x100, ack after 3 cycles with rdata 0xDEADBEEF → mem_addr 0x100, mem_be 1111, done at cycle 4, load_data 0xDEADBEEF, wb_sel 1.
- Signed byte load at 0x103, rdata 0x80112233 → mem_be 1000, load_data 0xFFFFFF80. Zero-extended variant → 0x00000080.
- Half store at 0x206, wdata 0x0000ABCD, ack next cycle → mem_we 1, mem_be 1100, mem_wdata 0xABCDABCD, done at cycle 2, wb_sel 0.
- Word load at 0x102 → err and done at cycle 1, mem_req never high, load_data unchanged, wb_sel 0.
- TIMEOUT=4, no ack → mem_req high cycles 1–4, err/done at cycle 5. A start pulsed at cycle 2 is ignored.
- rst_n low at cycle 2 of a pending load → mem_req, busy and load_data go to 0 immediately, no done. A new start after reset completes normally.
